// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: FSM encodings,
// the x0 register constant, and the bundle of per-cycle pipeline controls.
package riscv_ctrl_defs;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic stall_ex;
    logic stall_mem;
    logic bubble_ex;
    logic bubble_wb;
    logic flush_if;
    logic flush_id;
    logic redirect;
  } ctrl_t;

  // Wait counter is never narrower than 8 bits, wider when the timeout demands it.
  function automatic int wait_cnt_w(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 8) ? 8 : w;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard/status inputs and stall/flush/redirect outputs of the pipeline
// controller; master is the pipeline side, slave is the controller.
interface pipeline_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       ex_rd;
  logic             ex_mem_read;
  logic             ex_branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             wb_halt;
  logic             resume;

  logic             stall_if;
  logic             stall_id;
  logic             stall_ex;
  logic             stall_mem;
  logic             bubble_ex;
  logic             bubble_wb;
  logic             flush_if;
  logic             flush_id;
  logic             redirect;
  logic             halted;
  logic             err_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, mem_req, mem_ready, wb_halt, resume,
    input  stall_if, stall_id, stall_ex, stall_mem, bubble_ex, bubble_wb,
           flush_if, flush_id, redirect, halted, err_timeout,
           stall_cycles, flush_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, mem_req, mem_ready, wb_halt, resume,
    output stall_if, stall_id, stall_ex, stall_mem, bubble_ex, bubble_wb,
           flush_if, flush_id, redirect, halted, err_timeout,
           stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational load-use detector: the ID instruction reads a register that
// the load currently in EX has not yet produced.
module hazard_detect
  import riscv_ctrl_defs::*;
(
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_use_rs1_i,
  input  logic       id_use_rs2_i,
  input  logic [4:0] ex_rd_i,
  input  logic       ex_mem_read_i,
  output logic       load_use_o
);
  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_use_rs1_i & (id_rs1_i == ex_rd_i);
  assign rs2_hit = id_use_rs2_i & (id_rs2_i == ex_rd_i);

  // Writes to x0 are discarded, so a load targeting x0 never creates a hazard.
  assign load_use_o = ex_mem_read_i & (ex_rd_i != REG_X0) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer: RUN/MEM_WAIT/HALT state machine, memory-wait
// timeout, load-use and redirect arbitration, and stall/flush counters.
module pipeline_ctrl
  import riscv_ctrl_defs::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic            clk,
  input  logic            rst,
  pipeline_ctrl_if.slave  ctrl_if
);
  localparam int WAIT_W = wait_cnt_w(MEM_TIMEOUT);

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic   load_use;
  logic   mem_stall;
  logic   freeze;
  ctrl_t  ctrl;

  hazard_detect u_hazard (
    .id_rs1_i      (ctrl_if.id_rs1),
    .id_rs2_i      (ctrl_if.id_rs2),
    .id_use_rs1_i  (ctrl_if.id_use_rs1),
    .id_use_rs2_i  (ctrl_if.id_use_rs2),
    .ex_rd_i       (ctrl_if.ex_rd),
    .ex_mem_read_i (ctrl_if.ex_mem_read),
    .load_use_o    (load_use)
  );

  assign mem_stall = ctrl_if.mem_req & ~ctrl_if.mem_ready;
  assign freeze    = (state_q == ST_HALT) | (state_q == ST_MEM_WAIT) |
                     ((state_q == ST_RUN) & mem_stall);

  // Freeze holds the whole pipe, so EX's branch/load stay valid and their
  // actions are simply deferred until the freeze drops.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latch can form.
    ctrl = '0;
    if (freeze) begin
      ctrl.stall_if  = 1'b1;
      ctrl.stall_id  = 1'b1;
      ctrl.stall_ex  = 1'b1;
      ctrl.stall_mem = 1'b1;
      ctrl.bubble_wb = (state_q != ST_HALT);
    end else if (ctrl_if.ex_branch_taken) begin
      ctrl.redirect  = 1'b1;
      ctrl.flush_if  = 1'b1;
      ctrl.flush_id  = 1'b1;
      ctrl.bubble_ex = 1'b1;
    end else if (load_use) begin
      ctrl.stall_if  = 1'b1;
      ctrl.stall_id  = 1'b1;
      ctrl.bubble_ex = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    err_d   = err_q;
    case (state_q)
      ST_RUN: begin
        if (ctrl_if.wb_halt) begin
          state_d = ST_HALT;
        end else if (mem_stall) begin
          // The detecting RUN cycle is wait cycle 1.
          state_d = ST_MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (ctrl_if.mem_ready) begin
          state_d = ST_RUN;
          wait_d  = '0;
        end else if (wait_q >= WAIT_W'(MEM_TIMEOUT)) begin
          state_d = ST_HALT;
          err_d   = 1'b1;
          wait_d  = '0;
        end else begin
          wait_d  = wait_q + 1'b1;
        end
      end
      ST_HALT: begin
        if (ctrl_if.resume) begin
          state_d = ST_RUN;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_RUN;
        wait_d  = '0;
      end
    endcase

    stall_cnt_d = stall_cnt_q + CNT_W'(ctrl.stall_if);
    flush_cnt_d = flush_cnt_q + CNT_W'(ctrl.redirect);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      wait_q      <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking for all state so every register samples pre-edge values.
      state_q     <= state_d;
      wait_q      <= wait_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ctrl_if.stall_if     = ctrl.stall_if;
  assign ctrl_if.stall_id     = ctrl.stall_id;
  assign ctrl_if.stall_ex     = ctrl.stall_ex;
  assign ctrl_if.stall_mem    = ctrl.stall_mem;
  assign ctrl_if.bubble_ex    = ctrl.bubble_ex;
  assign ctrl_if.bubble_wb    = ctrl.bubble_wb;
  assign ctrl_if.flush_if     = ctrl.flush_if;
  assign ctrl_if.flush_id     = ctrl.flush_id;
  assign ctrl_if.redirect     = ctrl.redirect;
  assign ctrl_if.halted       = (state_q == ST_HALT);
  assign ctrl_if.err_timeout  = err_q;
  assign ctrl_if.stall_cycles = stall_cnt_q;
  assign ctrl_if.flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: each cycle's expected control vector is
// queued with its stimulus and compared half a cycle later.
module tb_pipeline_ctrl;

  typedef struct packed {
    logic stall_if, stall_id, stall_ex, stall_mem, bubble_ex, bubble_wb;
    logic flush_if, flush_id, redirect, halted, err_timeout;
  } ctl_t;

  typedef struct packed {
    logic [4:0] rs1; logic u1;
    logic [4:0] rs2; logic u2;
    logic [4:0] rd;  logic mr;
    logic br, req, rdy, halt, res;
  } stim_t;

  localparam ctl_t C_IDLE = 11'b00000000000;
  localparam ctl_t C_LU   = 11'b11001000000;
  localparam ctl_t C_BR   = 11'b00001011100;
  localparam ctl_t C_FRZ  = 11'b11110100000;
  localparam ctl_t C_HALT = 11'b11110000010;
  localparam ctl_t C_HERR = 11'b11110000011;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [31:0] exp_stalls = '0;
  logic [31:0] exp_flush  = '0;
  ctl_t exp_q[$];

  pipeline_ctrl_if #(.CNT_W(32)) bus ();

  pipeline_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .ctrl_if (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic stim_t mk(input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2,
                               input logic [4:0] rd, input logic mr, input logic br,
                               input logic req, input logic rdy,
                               input logic halt, input logic res);
    return {rs1, u1, rs2, u2, rd, mr, br, req, rdy, halt, res};
  endfunction

  localparam stim_t S_IDLE = {5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'b00000};
  localparam stim_t S_LU   = {5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'b00000};

  task automatic apply(input stim_t s);
    bus.id_rs1 = s.rs1;  bus.id_use_rs1 = s.u1;
    bus.id_rs2 = s.rs2;  bus.id_use_rs2 = s.u2;
    bus.ex_rd  = s.rd;   bus.ex_mem_read = s.mr;
    bus.ex_branch_taken = s.br;
    bus.mem_req = s.req; bus.mem_ready = s.rdy;
    bus.wb_halt = s.halt; bus.resume = s.res;
  endtask

  function automatic ctl_t observe();
    return {bus.stall_if, bus.stall_id, bus.stall_ex, bus.stall_mem, bus.bubble_ex,
            bus.bubble_wb, bus.flush_if, bus.flush_id, bus.redirect, bus.halted,
            bus.err_timeout};
  endfunction

  task automatic test_reset();
    ctl_t got, want;
    rst = 1'b1;
    apply(S_IDLE);
    exp_q.push_back(C_IDLE);
    #3;
    got = observe(); want = exp_q.pop_front();
    n_checks++;
    if (got !== want) begin
      n_fail++; $display("FAIL reset_idle: ctl got %b expected %b", got, want);
    end
    n_checks++;
    if (bus.stall_cycles !== 32'd0 || bus.flush_count !== 32'd0) begin
      n_fail++; $display("FAIL reset_counters: got %0d/%0d expected 0/0",
                         bus.stall_cycles, bus.flush_count);
    end
    apply(S_LU);
    exp_q.push_back(C_LU);
    #1;
    got = observe(); want = exp_q.pop_front();
    n_checks++;
    if (got !== want) begin
      n_fail++; $display("FAIL reset_run_rules: ctl got %b expected %b", got, want);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.stall_cycles !== 32'd0) begin
      n_fail++; $display("FAIL reset_hold_count: got %0d expected 0", bus.stall_cycles);
    end
    apply(S_IDLE);
    rst = 1'b0;
  endtask

  task automatic test_load_use();
    stim_t st[6]; ctl_t ex[6]; ctl_t got, want;
    st[0] = S_LU;                                          ex[0] = C_LU;
    st[1] = S_IDLE;                                        ex[1] = C_IDLE;
    st[2] = mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);           ex[2] = C_IDLE;
    st[3] = mk(3, 1, 7, 1, 7, 1, 0, 0, 0, 0, 0);           ex[3] = C_LU;
    st[4] = mk(9, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0);           ex[4] = C_IDLE;
    st[5] = mk(9, 1, 0, 0, 9, 0, 0, 0, 0, 0, 0);           ex[5] = C_IDLE;
    for (int i = 0; i < 6; i++) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      got = observe(); want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL load_use[%0d]: ctl got %b expected %b", i, got, want);
      end
      exp_stalls = exp_stalls + 32'(want.stall_if);
      exp_flush  = exp_flush + 32'(want.redirect);
      @(posedge clk); #1;
    end
    n_checks++;
    if (bus.stall_cycles !== exp_stalls) begin
      n_fail++; $display("FAIL load_use_count: got %0d expected %0d", bus.stall_cycles, exp_stalls);
    end
  endtask

  task automatic test_redirect();
    stim_t st[2]; ctl_t ex[2]; ctl_t got, want;
    st[0] = mk(5, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0);           ex[0] = C_BR;
    st[1] = S_IDLE;                                        ex[1] = C_IDLE;
    for (int i = 0; i < 2; i++) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      got = observe(); want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL redirect[%0d]: ctl got %b expected %b", i, got, want);
      end
      exp_stalls = exp_stalls + 32'(want.stall_if);
      exp_flush  = exp_flush + 32'(want.redirect);
      @(posedge clk); #1;
    end
    n_checks++;
    if (bus.flush_count !== exp_flush || bus.stall_cycles !== exp_stalls) begin
      n_fail++; $display("FAIL redirect_count: got %0d/%0d expected %0d/%0d",
                         bus.flush_count, bus.stall_cycles, exp_flush, exp_stalls);
    end
  endtask

  task automatic test_mem_wait();
    stim_t st[8]; ctl_t ex[8]; ctl_t got, want;
    // ready in the first RUN cycle: no freeze, stays in RUN
    st[0] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);           ex[0] = C_IDLE;
    st[1] = S_IDLE;                                        ex[1] = C_IDLE;
    // three not-ready cycles, then ready, with a pending taken branch
    st[2] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);           ex[2] = C_FRZ;
    st[3] = st[2];                                         ex[3] = C_FRZ;
    st[4] = st[2];                                         ex[4] = C_FRZ;
    st[5] = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0);           ex[5] = C_FRZ;
    st[6] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);           ex[6] = C_BR;
    st[7] = S_IDLE;                                        ex[7] = C_IDLE;
    for (int i = 0; i < 8; i++) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      got = observe(); want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL mem_wait[%0d]: ctl got %b expected %b", i, got, want);
      end
      exp_stalls = exp_stalls + 32'(want.stall_if);
      exp_flush  = exp_flush + 32'(want.redirect);
      @(posedge clk); #1;
    end
    n_checks++;
    if (bus.stall_cycles !== exp_stalls || bus.flush_count !== exp_flush) begin
      n_fail++; $display("FAIL mem_wait_count: got %0d/%0d expected %0d/%0d",
                         bus.stall_cycles, bus.flush_count, exp_stalls, exp_flush);
    end
  endtask

  task automatic test_timeout();
    stim_t st[15]; ctl_t ex[15]; ctl_t got, want;
    stim_t wait_s;
    wait_s = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    // ready arrives exactly when the counter hits the limit: back to RUN
    for (int i = 0; i < 4; i++) begin st[i] = wait_s; ex[i] = C_FRZ; end
    st[4]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);          ex[4]  = C_FRZ;
    st[5]  = S_IDLE;                                       ex[5]  = C_IDLE;
    // ready never comes: four MEM_WAIT cycles then HALT with the fault
    for (int i = 6; i < 11; i++) begin st[i] = wait_s; ex[i] = C_FRZ; end
    st[11] = wait_s;                                       ex[11] = C_HERR;
    st[12] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);          ex[12] = C_HERR;
    st[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);          ex[13] = C_HERR;
    st[14] = S_IDLE;                                       ex[14] = C_IDLE;
    for (int i = 0; i < 15; i++) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      got = observe(); want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL timeout[%0d]: ctl got %b expected %b", i, got, want);
      end
      exp_stalls = exp_stalls + 32'(want.stall_if);
      exp_flush  = exp_flush + 32'(want.redirect);
      @(posedge clk); #1;
    end
    n_checks++;
    if (bus.stall_cycles !== exp_stalls || bus.flush_count !== exp_flush) begin
      n_fail++; $display("FAIL timeout_count: got %0d/%0d expected %0d/%0d",
                         bus.stall_cycles, bus.flush_count, exp_stalls, exp_flush);
    end
  endtask

  task automatic test_halt();
    stim_t st[10]; ctl_t ex[10]; ctl_t got, want;
    st[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);           ex[0] = C_IDLE;
    st[1] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);           ex[1] = C_BR;
    st[2] = S_IDLE;                                        ex[2] = C_HALT;
    st[3] = S_LU;                                          ex[3] = C_HALT;
    st[4] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);           ex[4] = C_HALT;
    st[5] = S_IDLE;                                        ex[5] = C_IDLE;
    // halt wins over a simultaneous memory wait
    st[6] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);           ex[6] = C_FRZ;
    st[7] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);           ex[7] = C_HALT;
    st[8] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);           ex[8] = C_HALT;
    st[9] = S_IDLE;                                        ex[9] = C_IDLE;
    for (int i = 0; i < 10; i++) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      got = observe(); want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL halt[%0d]: ctl got %b expected %b", i, got, want);
      end
      exp_stalls = exp_stalls + 32'(want.stall_if);
      exp_flush  = exp_flush + 32'(want.redirect);
      @(posedge clk); #1;
    end
    n_checks++;
    if (bus.stall_cycles !== exp_stalls || bus.flush_count !== exp_flush) begin
      n_fail++; $display("FAIL halt_count: got %0d/%0d expected %0d/%0d",
                         bus.stall_cycles, bus.flush_count, exp_stalls, exp_flush);
    end
  endtask

  task automatic test_reset_mid_wait();
    ctl_t got, want;
    for (int i = 0; i < 2; i++) begin
      apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      exp_q.push_back(C_FRZ);
      @(negedge clk);
      got = observe(); want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL mid_wait_enter[%0d]: ctl got %b expected %b", i, got, want);
      end
      exp_stalls = exp_stalls + 32'(want.stall_if);
      @(posedge clk); #1;
    end
    // MEM_WAIT freezes even with the memory request gone
    apply(S_LU);
    exp_q.push_back(C_FRZ);
    #1;
    got = observe(); want = exp_q.pop_front();
    n_checks++;
    if (got !== want) begin
      n_fail++; $display("FAIL mid_wait_frozen: ctl got %b expected %b", got, want);
    end
    rst = 1'b1;
    exp_stalls = '0;
    exp_flush  = '0;
    exp_q.push_back(C_LU);
    #1;
    got = observe(); want = exp_q.pop_front();
    n_checks++;
    if (got !== want) begin
      n_fail++; $display("FAIL mid_wait_reset: ctl got %b expected %b", got, want);
    end
    n_checks++;
    if (bus.stall_cycles !== exp_stalls || bus.flush_count !== exp_flush) begin
      n_fail++; $display("FAIL mid_wait_reset_count: got %0d/%0d expected 0/0",
                         bus.stall_cycles, bus.flush_count);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    @(posedge clk); #1;
    apply(S_IDLE);
    exp_q.push_back(C_HALT);
    #1;
    got = observe(); want = exp_q.pop_front();
    n_checks++;
    if (got !== want) begin
      n_fail++; $display("FAIL mid_halt_enter: ctl got %b expected %b", got, want);
    end
    rst = 1'b1;
    exp_q.push_back(C_IDLE);
    #1;
    got = observe(); want = exp_q.pop_front();
    n_checks++;
    if (got !== want) begin
      n_fail++; $display("FAIL mid_halt_reset: ctl got %b expected %b", got, want);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (bus.stall_cycles !== exp_stalls || bus.flush_count !== exp_flush) begin
      n_fail++; $display("FAIL mid_halt_reset_count: got %0d/%0d expected 0/0",
                         bus.stall_cycles, bus.flush_count);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_use();
    test_redirect();
    test_mem_wait();
    test_timeout();
    test_halt();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
